// File: rtl/tcam_pkg.sv
// Shared definitions for the ternary match table controller: FSM encoding,
// default geometry, the miss index and the entry-count clamp.
package tcam_pkg;

  localparam int TCAM_ADDR_WIDTH = 3;
  localparam int TCAM_KEY_WIDTH  = 144;
  localparam int TCAM_SUM_DEF    = 8;
  localparam int TCAM_MISS_IDX   = TCAM_SUM_DEF - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOOK  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Index reported on a miss for a table of the given size.
  function automatic int unsigned miss_index(input int unsigned tcam_sum);
    return tcam_sum - 1;
  endfunction

  // Counts above the table size saturate at the table size.
  function automatic int unsigned clamp_count(input int unsigned num,
                                              input int unsigned limit);
    return (num > limit) ? limit : num;
  endfunction

endpackage

// File: rtl/tcam_match_enc.sv
// Combinational ternary compare of one key against every table entry, followed
// by a lowest-index priority encoder gated by the programmed-entry count.
module tcam_match_enc
  import tcam_pkg::*;
#(
  parameter int ADDR_WIDTH = TCAM_ADDR_WIDTH,
  parameter int KEY_WIDTH  = TCAM_KEY_WIDTH,
  parameter int TCAM_SUM   = TCAM_SUM_DEF,
  parameter int MISS_IDX   = TCAM_MISS_IDX
) (
  input  logic [TCAM_SUM*KEY_WIDTH-1:0] table_key,
  input  logic [TCAM_SUM*KEY_WIDTH-1:0] table_mask,
  input  logic [KEY_WIDTH-1:0]          key,
  input  logic [ADDR_WIDTH:0]           valid_num,
  output logic                          hit,
  output logic [ADDR_WIDTH-1:0]         idx
);

  logic [TCAM_SUM-1:0]   match_vec;
  logic                  found;
  logic [ADDR_WIDTH-1:0] first_idx;

  // A mask bit of 1 removes that key bit from the comparison.
  always_comb begin
    match_vec = '0;
    for (int i = 0; i < TCAM_SUM; i++) begin
      match_vec[i] = ((table_key[i*KEY_WIDTH +: KEY_WIDTH] ^ key) &
                      ~table_mask[i*KEY_WIDTH +: KEY_WIDTH]) == '0;
    end
  end

  always_comb begin
    found     = 1'b0;
    first_idx = ADDR_WIDTH'(MISS_IDX);
    for (int i = TCAM_SUM - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        found     = 1'b1;
        first_idx = ADDR_WIDTH'(i);
      end
    end
  end

  // Only the lowest match decides; if it lies beyond the count it is a miss.
  assign hit = found && ({1'b0, first_idx} < valid_num);
  assign idx = hit ? first_idx : ADDR_WIDTH'(MISS_IDX);

endmodule

// File: rtl/tcam_lookup_ctrl.sv
// Owner of the parser's ternary match table: config writes, count updates, a
// sweeping table clear and a serialised request/response lookup path.
module tcam_lookup_ctrl
  import tcam_pkg::*;
#(
  parameter int ADDR_WIDTH = TCAM_ADDR_WIDTH,
  parameter int KEY_WIDTH  = TCAM_KEY_WIDTH,
  parameter int TCAM_SUM   = TCAM_SUM_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_wr_valid,
  output logic                  cfg_wr_ready,
  input  logic [ADDR_WIDTH-1:0] cfg_wr_addr,
  input  logic [KEY_WIDTH-1:0]  cfg_wr_key,
  input  logic [KEY_WIDTH-1:0]  cfg_wr_mask,
  input  logic                  cfg_num_wr,
  input  logic [ADDR_WIDTH:0]   cfg_num,
  input  logic                  clr_start,
  output logic                  busy,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [KEY_WIDTH-1:0]  req_key,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_hit,
  output logic [ADDR_WIDTH-1:0] rsp_addr
);

  localparam int TBL_WIDTH = TCAM_SUM * KEY_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] MISS_ADDR = ADDR_WIDTH'(miss_index(TCAM_SUM));

  if (TCAM_SUM != (2 ** ADDR_WIDTH)) begin : g_bad_geometry
    $error("tcam_lookup_ctrl: TCAM_SUM must equal 2**ADDR_WIDTH");
  end

  state_e                state_q,     state_d;
  logic [TBL_WIDTH-1:0]  tbl_key_q,   tbl_key_d;
  logic [TBL_WIDTH-1:0]  tbl_mask_q,  tbl_mask_d;
  logic [ADDR_WIDTH:0]   valid_num_q, valid_num_d;
  logic [ADDR_WIDTH-1:0] clr_idx_q,   clr_idx_d;
  logic [KEY_WIDTH-1:0]  req_key_q,   req_key_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_hit_q,   rsp_hit_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q,  rsp_addr_d;

  logic                  idle;
  logic                  match_hit;
  logic [ADDR_WIDTH-1:0] match_idx;

  assign idle         = (state_q == ST_IDLE);
  assign cfg_wr_ready = idle && !clr_start;
  assign req_ready    = cfg_wr_ready && !cfg_wr_valid && !cfg_num_wr;
  assign busy         = !idle;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_hit      = rsp_hit_q;
  assign rsp_addr     = rsp_addr_q;

  tcam_match_enc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .KEY_WIDTH  (KEY_WIDTH),
    .TCAM_SUM   (TCAM_SUM),
    .MISS_IDX   (int'(miss_index(TCAM_SUM)))
  ) u_match_enc (
    .table_key  (tbl_key_q),
    .table_mask (tbl_mask_q),
    .key        (req_key_q),
    .valid_num  (valid_num_q),
    .hit        (match_hit),
    .idx        (match_idx)
  );

  always_comb begin
    state_d     = state_q;
    tbl_key_d   = tbl_key_q;
    tbl_mask_d  = tbl_mask_q;
    valid_num_d = valid_num_q;
    clr_idx_d   = clr_idx_q;
    req_key_d   = req_key_q;
    rsp_valid_d = rsp_valid_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_addr_d  = rsp_addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d     = ST_CLEAR;
          valid_num_d = '0;
          clr_idx_d   = '0;
        end else if (cfg_wr_valid || cfg_num_wr) begin
          if (cfg_wr_valid) begin
            tbl_key_d[32'(cfg_wr_addr)*KEY_WIDTH +: KEY_WIDTH]  = cfg_wr_key;
            tbl_mask_d[32'(cfg_wr_addr)*KEY_WIDTH +: KEY_WIDTH] = cfg_wr_mask;
          end
          if (cfg_num_wr) begin
            valid_num_d = (ADDR_WIDTH+1)'(clamp_count(32'(cfg_num), TCAM_SUM));
          end
        end else if (req_valid) begin
          req_key_d = req_key;
          state_d   = ST_LOOK;
        end
      end

      // One entry per cycle; the index wraps back to zero after the last one.
      ST_CLEAR: begin
        tbl_key_d[32'(clr_idx_q)*KEY_WIDTH +: KEY_WIDTH]  = '0;
        tbl_mask_d[32'(clr_idx_q)*KEY_WIDTH +: KEY_WIDTH] = '0;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == MISS_ADDR) begin
          state_d = ST_IDLE;
        end
      end

      ST_LOOK: begin
        rsp_valid_d = 1'b1;
        rsp_hit_d   = match_hit;
        rsp_addr_d  = match_idx;
        state_d     = ST_RESP;
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tbl_key_q   <= '0;
      tbl_mask_q  <= '0;
      valid_num_q <= '0;
      clr_idx_q   <= '0;
      req_key_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_addr_q  <= MISS_ADDR;
    end else begin
      state_q     <= state_d;
      tbl_key_q   <= tbl_key_d;
      tbl_mask_q  <= tbl_mask_d;
      valid_num_q <= valid_num_d;
      clr_idx_q   <= clr_idx_d;
      req_key_q   <= req_key_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_addr_q  <= rsp_addr_d;
    end
  end

endmodule

// File: tb/tb_tcam_lookup_ctrl.sv
// Bench for tcam_lookup_ctrl: directed scenarios with literal expectations plus
// a randomized phase, all compared every cycle against a transaction-level model.
module tb_tcam_lookup_ctrl;

  localparam int AW = 3;
  localparam int KW = 144;
  localparam int NE = 8;

  logic          clk;
  logic          rst_n;
  logic          cfg_wr_valid;
  logic          cfg_wr_ready;
  logic [AW-1:0] cfg_wr_addr;
  logic [KW-1:0] cfg_wr_key;
  logic [KW-1:0] cfg_wr_mask;
  logic          cfg_num_wr;
  logic [AW:0]   cfg_num;
  logic          clr_start;
  logic          busy;
  logic          req_valid;
  logic          req_ready;
  logic [KW-1:0] req_key;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_hit;
  logic [AW-1:0] rsp_addr;

  int checks = 0;
  int errors = 0;

  tcam_lookup_ctrl #(
    .ADDR_WIDTH (AW),
    .KEY_WIDTH  (KW),
    .TCAM_SUM   (NE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_wr_valid (cfg_wr_valid),
    .cfg_wr_ready (cfg_wr_ready),
    .cfg_wr_addr  (cfg_wr_addr),
    .cfg_wr_key   (cfg_wr_key),
    .cfg_wr_mask  (cfg_wr_mask),
    .cfg_num_wr   (cfg_num_wr),
    .cfg_num      (cfg_num),
    .clr_start    (clr_start),
    .busy         (busy),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_key      (req_key),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_hit      (rsp_hit),
    .rsp_addr     (rsp_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level reference: a table, a count, a clear countdown and a
  // lookup stage (0 none, 1 comparing, 2 result held).
  logic [KW-1:0] m_key  [NE];
  logic [KW-1:0] m_mask [NE];
  int            m_num;
  int            m_clr_left;
  int            m_stage;
  int            m_pend_code;
  logic          m_rsp_hit;
  logic [7:0]    m_rsp_addr;
  logic          m_idle;

  assign m_idle = (m_clr_left == 0) && (m_stage == 0);

  // Result code: bit 8 = hit, bits 7:0 = reported index.
  function automatic int model_lookup(input logic [KW-1:0] k);
    for (int i = 0; i < NE; i++) begin
      if (((m_key[i] ^ k) & ~m_mask[i]) == '0) begin
        if (i < m_num) return 256 + i;
        return NE - 1;
      end
    end
    return NE - 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NE; i++) begin
        m_key[i]  <= '0;
        m_mask[i] <= '0;
      end
      m_num       <= 0;
      m_clr_left  <= 0;
      m_stage     <= 0;
      m_pend_code <= NE - 1;
      m_rsp_hit   <= 1'b0;
      m_rsp_addr  <= 8'(NE - 1);
    end else if (m_clr_left > 0) begin
      m_clr_left <= m_clr_left - 1;
    end else if (m_stage == 1) begin
      m_stage    <= 2;
      m_rsp_hit  <= m_pend_code[8];
      m_rsp_addr <= m_pend_code[7:0];
    end else if (m_stage == 2) begin
      if (rsp_ready) m_stage <= 0;
    end else if (clr_start) begin
      m_clr_left <= NE;
      m_num      <= 0;
      for (int i = 0; i < NE; i++) begin
        m_key[i]  <= '0;
        m_mask[i] <= '0;
      end
    end else if (cfg_wr_valid || cfg_num_wr) begin
      if (cfg_wr_valid) begin
        m_key[cfg_wr_addr]  <= cfg_wr_key;
        m_mask[cfg_wr_addr] <= cfg_wr_mask;
      end
      if (cfg_num_wr) m_num <= (int'(cfg_num) > NE) ? NE : int'(cfg_num);
    end else if (req_valid) begin
      m_pend_code <= model_lookup(req_key);
      m_stage     <= 1;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("model_busy", int'(busy), int'(!m_idle));
      checkOutput("model_cfg_wr_ready", int'(cfg_wr_ready), int'(m_idle && !clr_start));
      checkOutput("model_req_ready", int'(req_ready),
                  int'(m_idle && !clr_start && !cfg_wr_valid && !cfg_num_wr));
      checkOutput("model_rsp_valid", int'(rsp_valid), int'(m_stage == 2));
      if (m_stage == 2) begin
        checkOutput("model_rsp_hit", int'(rsp_hit), int'(m_rsp_hit));
        checkOutput("model_rsp_addr", int'(rsp_addr), int'(m_rsp_addr));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_idle();
    cfg_wr_valid = 1'b0;
    cfg_wr_addr  = '0;
    cfg_wr_key   = '0;
    cfg_wr_mask  = '0;
    cfg_num_wr   = 1'b0;
    cfg_num      = '0;
    clr_start    = 1'b0;
    req_valid    = 1'b0;
    req_key      = '0;
    rsp_ready    = 1'b0;
  endtask

  task automatic cfg_write(input int addr, input logic [KW-1:0] key,
                           input logic [KW-1:0] mask, input bit do_num, input int num);
    cfg_wr_valid = 1'b1;
    cfg_wr_addr  = AW'(addr);
    cfg_wr_key   = key;
    cfg_wr_mask  = mask;
    cfg_num_wr   = do_num;
    cfg_num      = (AW+1)'(num);
    step();
    cfg_wr_valid = 1'b0;
    cfg_num_wr   = 1'b0;
  endtask

  task automatic cfg_num_only(input int num);
    cfg_num_wr = 1'b1;
    cfg_num    = (AW+1)'(num);
    step();
    cfg_num_wr = 1'b0;
  endtask

  task automatic lookup(input string name, input logic [KW-1:0] key,
                        input int exp_hit, input int exp_addr, input int hold);
    req_valid = 1'b1;
    req_key   = key;
    #1;
    checkOutput({name, "_req_ready"}, int'(req_ready), 1);
    step();
    req_valid = 1'b0;
    checkOutput({name, "_lat1_valid"}, int'(rsp_valid), 0);
    step();
    checkOutput({name, "_lat2_valid"}, int'(rsp_valid), 1);
    checkOutput({name, "_hit"}, int'(rsp_hit), exp_hit);
    checkOutput({name, "_addr"}, int'(rsp_addr), exp_addr);
    for (int h = 0; h < hold; h++) begin
      step();
      checkOutput({name, "_hold_valid"}, int'(rsp_valid), 1);
      checkOutput({name, "_hold_hit"}, int'(rsp_hit), exp_hit);
      checkOutput({name, "_hold_addr"}, int'(rsp_addr), exp_addr);
      checkOutput({name, "_hold_req_ready"}, int'(req_ready), 0);
      checkOutput({name, "_hold_busy"}, int'(busy), 1);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checkOutput({name, "_done_valid"}, int'(rsp_valid), 0);
    checkOutput({name, "_done_req_ready"}, int'(req_ready), 1);
  endtask

  task automatic check_reset_values(input string name);
    checkOutput({name, "_rsp_valid"}, int'(rsp_valid), 0);
    checkOutput({name, "_rsp_hit"}, int'(rsp_hit), 0);
    checkOutput({name, "_rsp_addr"}, int'(rsp_addr), NE - 1);
    checkOutput({name, "_busy"}, int'(busy), 0);
    checkOutput({name, "_req_ready"}, int'(req_ready), 1);
    checkOutput({name, "_cfg_wr_ready"}, int'(cfg_wr_ready), 1);
  endtask

  function automatic logic [KW-1:0] pool_key(input int sel);
    logic [KW-1:0] k;
    case (sel)
      0:       k = '0;
      1:       k = KW'(32'h55);
      2:       k = {16'hBEEF, 128'h3};
      default: k = '1;
    endcase
    return k;
  endfunction

  function automatic logic [KW-1:0] rand_mask();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return '1;
    if (r <= 2) return KW'($urandom_range(0, 15));
    return '0;
  endfunction

  // One cycle of random traffic on every input.
  task automatic applyStimulus();
    clr_start    = ($urandom_range(0, 63) == 0);
    cfg_wr_valid = ($urandom_range(0, 5) == 0);
    cfg_num_wr   = ($urandom_range(0, 7) == 0);
    cfg_wr_addr  = AW'($urandom_range(0, NE - 1));
    cfg_wr_key   = pool_key($urandom_range(0, 3));
    cfg_wr_mask  = rand_mask();
    cfg_num      = (AW+1)'($urandom_range(0, 15));
    req_valid    = ($urandom_range(0, 2) == 0);
    req_key      = pool_key($urandom_range(0, 3));
    if ($urandom_range(0, 3) == 0) req_key = req_key ^ KW'($urandom_range(1, 3));
    rsp_ready    = ($urandom_range(0, 1) == 1);
    step();
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #2;
    check_reset_values("in_reset");
    rst_n = 1'b1;
    #1;
    check_reset_values("after_reset");
    step();

    lookup("reset_key0", '0, 0, NE - 1, 0);

    cfg_write(2, KW'(32'hAB), '0, 1'b1, 8);
    lookup("exact_hit", KW'(32'hAB), 1, 2, 0);

    cfg_write(0, KW'(32'h10), '0, 1'b0, 0);
    cfg_write(1, '0, '1, 1'b0, 0);
    lookup("prio_0x10", KW'(32'h10), 1, 0, 0);
    lookup("wild_0x11", KW'(32'h11), 1, 1, 0);

    cfg_write(0, KW'(32'h1), '0, 1'b0, 0);
    cfg_write(1, KW'(32'h2), '0, 1'b0, 0);
    cfg_write(3, KW'(32'h55), '0, 1'b1, 1);
    lookup("gate_num1", KW'(32'h55), 0, NE - 1, 0);
    cfg_num_only(4);
    lookup("gate_num4", KW'(32'h55), 1, 3, 0);
    cfg_write(7, KW'(32'h66), '0, 1'b1, 12);
    lookup("clamp_num12", KW'(32'h66), 1, 7, 0);

    lookup("backpressure", KW'(32'hAB), 1, 2, 5);

    clr_start    = 1'b1;
    cfg_wr_valid = 1'b1;
    cfg_wr_addr  = 3'd5;
    cfg_wr_key   = KW'(32'hAB);
    cfg_wr_mask  = '0;
    req_valid    = 1'b1;
    req_key      = KW'(32'hAB);
    #1;
    checkOutput("contend_cfg_wr_ready", int'(cfg_wr_ready), 0);
    checkOutput("contend_req_ready", int'(req_ready), 0);
    step();
    drive_idle();
    n = 0;
    while (busy && n < 20) begin
      n++;
      step();
    end
    if (n >= 20) $display("[TB] FAIL clear_timeout: busy still %0d after %0d cycles, required 0", busy, n);
    checkOutput("clear_busy_cycles", n, NE);
    lookup("after_clear", KW'(32'hAB), 0, NE - 1, 0);

    cfg_num_only(8);
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    checkOutput("clear2_busy", int'(busy), 1);
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_reset_values("reset_mid_clear");
    step();
    step();
    rst_n = 1'b1;
    #1;
    check_reset_values("released_mid_clear");
    step();

    for (int c = 0; c < 3000; c++) applyStimulus();
    drive_idle();
    rsp_ready = 1'b1;
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
